if_scratch_read_module: RTL and testbench
=========================================

# if_scratch_read_module

Consumer side of the IF scratchpad. It walks the circular IF window `[start_IF, end_IF]` filled by the IF buffer-read block and issues scratchpad read addresses as sliding filter windows of `filt_len` elements advanced by `stride`. It never reads a slot that has not been written yet. When no further window fits inside a closed row, it pulses `full_done` so the writer can release the row and begin the next.

## Interface
Parameters:
- `ADDR_LEN`, 4: scratchpad address width.
- `SCRATCH_DEPTH`, 16: number of scratchpad entries; must satisfy `SCRATCH_DEPTH` ≤ 2^`ADDR_LEN`.
- `SCRATCH_WIDTH`, 8: data width. Not used internally; carried for consistency.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: restart request; forces INIT from any state.
- `start_IF` in `ADDR_LEN`: writer's row start pointer.
- `end_IF` in `ADDR_LEN`: writer's row end pointer (inclusive).
- `IF_end_valid` in 1: `end_IF` is final for the current row.
- `IF_waddr` in `ADDR_LEN`: writer's next write slot.
- `filt_len` in `ADDR_LEN`: window length, ≥1. Sampled in INIT.
- `stride` in `ADDR_LEN`: window step, ≥1. Sampled in INIT.
- `stall` in 1: downstream not ready; blocks new reads.
- `IF_raddr` out `ADDR_LEN`: scratchpad read address.
- `IF_scratch_ren` out 1: read enable.
- `IF_rd_valid` out 1: scratchpad data valid this cycle.
- `window_last` out 1: qualifies `IF_rd_valid`; marks the last element of a window.
- `full_done` out 1: one-cycle row-release pulse.

## Operation
- States: IDLE, INIT, READ, DONE, WAIT.
  - IDLE → INIT on `start`.
  - INIT → READ unconditionally.
  - READ → DONE on the fit-fail condition below.
  - DONE → WAIT unconditionally.
  - WAIT → INIT when `IF_end_valid`=0.
  - `start` in any state → INIT. This takes priority over all other transitions.
- INIT:
  - Latch `filt_len` into `flen_r` and `stride` into `stride_r`.
  - Clear `base_off` and `cur`.
  - No outputs asserted.
- Offset arithmetic:
  - All offsets are ADDR_LEN+1 bits wide and measured modulo `SCRATCH_DEPTH` from `start_IF`.
  - `wr_cnt` = (`IF_waddr` − `start_IF`) mod D.
  - `end_off` = (`end_IF` − `start_IF`) mod D.
  - `off` = `base_off` + `cur`.
  - `IF_raddr` = (`start_IF` + `off`) mod D. Implement the mod as an add followed by a conditional subtract of D; no divider.
- Availability:
  - Element `off` is readable when `off` < `wr_cnt`.
  - It is also readable when `IF_end_valid`=1 and `off` ≤ `end_off`.
- Fit-fail is evaluated only in READ with `cur`=0. It fires when `IF_end_valid`=1 and `base_off` + `flen_r` − 1 > `end_off`.
- Issue rule in READ: `IF_scratch_ren`=1 when the element is available, `stall`=0, and fit-fail is false.
- On each issue:
  - If `cur`=`flen_r`−1, the window is complete: set `base_off` += `stride_r` and `cur`=0.
  - Otherwise `cur` += 1.
- If the element is not yet written, READ holds. No read is issued and no state changes.
- DONE: `full_done`=1 for exactly one cycle. No reads are issued.
- WAIT: hold until the writer drops `IF_end_valid`, which it does on receiving `full_done`. Then re-enter INIT to read the next row from the updated `start_IF`.
- Rows shorter than one window (`filt_len` > `end_off`+1) go straight to DONE with zero reads.

## Timing
- Reset values: state=IDLE. `base_off`, `cur`, `IF_raddr`, `IF_scratch_ren`, `IF_rd_valid`, `window_last` and `full_done` are all 0.
- `IF_raddr` and `IF_scratch_ren` are combinational from state, counters and inputs in the same cycle.
- `IF_rd_valid` is `IF_scratch_ren` delayed by 1 cycle. `window_last` is the registered "last element" flag for that issue.
- Throughput: one read per cycle when unstalled and data is available.
  - Each window costs exactly `flen_r` issue cycles. There is no bubble between windows.
  - Fit-fail → DONE → WAIT costs 2 cycles minimum before INIT.
- `stall` gates only new issues. A read issued in the cycle before `stall` rises still produces `IF_rd_valid` one cycle later, so downstream must absorb one extra beat.
- Reset or `start` mid-row drops any in-flight `IF_rd_valid` on the next cycle. The row restarts at offset 0.
- Overlapping windows (`stride` < `filt_len`) re-read the same slots. This is legal because the writer never overwrites a slot before `full_done`.

## Test plan
- D=16, `start_IF`=0, `end_IF`=7, `IF_end_valid`=1, `filt_len`=3, `stride`=1 → 6 windows (addresses 0-1-2 through 5-6-7), 18 `IF_rd_valid` beats, 6 `window_last` beats, then a single `full_done` pulse.
- Wrap-around: `start_IF`=14, `end_IF`=3, `filt_len`=3, `stride`=2 → reads 14,15,0 then 0,1,2; fit-fail at `base_off`=4; `full_done` pulses once.
- Writer lag: `IF_end_valid`=0, `IF_waddr` advancing by 1 every 3 cycles from `start_IF`=0 → `IF_raddr` never reaches `IF_waddr`; reads resume the cycle after each write.
- Short row: `start_IF`=5, `end_IF`=6, `filt_len`=4 → zero reads; `full_done` pulses 1 cycle after INIT→READ.
- `stall` held high for 4 cycles mid-window → no `IF_scratch_ren` during the stall, exactly 1 trailing `IF_rd_valid`; read sequence continues unchanged afterwards.
- `rst` asserted mid-window, then `start` → all outputs 0 on the next cycle; the next row begins at `IF_raddr`=`start_IF`.

Source files
------------

// File: rtl/if_scratch_read_module.sv
// if_scratch_read_module: walks the circular IF window as sliding filter windows
// and issues scratchpad reads only for slots the writer has already filled.
module if_scratch_read_module #(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_DEPTH = 16,
    parameter int SCRATCH_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] start_IF,
    input  logic [ADDR_LEN-1:0] end_IF,
    input  logic                IF_end_valid,
    input  logic [ADDR_LEN-1:0] IF_waddr,
    input  logic [ADDR_LEN-1:0] filt_len,
    input  logic [ADDR_LEN-1:0] stride,
    input  logic                stall,
    output logic [ADDR_LEN-1:0] IF_raddr,
    output logic                IF_scratch_ren,
    output logic                IF_rd_valid,
    output logic                window_last,
    output logic                full_done
);
    // One extra bit beyond the offset width so base_off + flen_r never overflows
    localparam int W = ADDR_LEN + 2;
    localparam logic [W-1:0] D = W'(SCRATCH_DEPTH);

    if (SCRATCH_DEPTH > (1 << ADDR_LEN) || SCRATCH_WIDTH < 1) begin : g_param_check
        $error("if_scratch_read_module: invalid parameters");
    end

    typedef enum logic [2:0] {IDLE, INIT, READ, DONE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] flen_q, flen_d, stride_q, stride_d, cur_q, cur_d;
    logic [ADDR_LEN:0]   base_q, base_d;
    logic                rd_valid_q, last_q;
    logic [W-1:0]        wr_cnt, end_off, off;
    logic                avail, fit_fail, is_last, ren;

    function automatic logic [W-1:0] wrap(input logic [W-1:0] x);
        return (x >= D) ? x - D : x;
    endfunction

    always_comb begin
        wr_cnt   = wrap(W'(IF_waddr) + D - W'(start_IF));
        end_off  = wrap(W'(end_IF) + D - W'(start_IF));
        off      = W'(base_q) + W'(cur_q);
        avail    = (off < wr_cnt) || (IF_end_valid && off <= end_off);
        fit_fail = state_q == READ && cur_q == '0 && IF_end_valid &&
                   (W'(base_q) + W'(flen_q) > end_off + W'(1));
        is_last  = cur_q == flen_q - 1'b1;
        ren      = state_q == READ && !start && !stall && avail && !fit_fail;
        IF_scratch_ren = ren;
        IF_raddr       = ren ? ADDR_LEN'(wrap(W'(start_IF) + off)) : '0;
        full_done      = state_q == DONE;
    end

    always_comb begin
        state_d  = state_q;
        flen_d   = flen_q;
        stride_d = stride_q;
        base_d   = base_q;
        cur_d    = cur_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            INIT:    state_d = READ;
            READ:    state_d = fit_fail ? DONE : READ;
            DONE:    state_d = WAIT;
            WAIT:    state_d = IF_end_valid ? WAIT : INIT;
            default: state_d = IDLE;
        endcase
        if (start) state_d = INIT;
        if (state_q == INIT) begin
            flen_d   = filt_len;
            stride_d = stride;
            base_d   = '0;
            cur_d    = '0;
        end
        if (ren) begin
            base_d = is_last ? base_q + {1'b0, stride_q} : base_q;
            cur_d  = is_last ? '0 : cur_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flen_q     <= '0;
            stride_q   <= '0;
            base_q     <= '0;
            cur_q      <= '0;
            rd_valid_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            flen_q     <= flen_d;
            stride_q   <= stride_d;
            base_q     <= base_d;
            cur_q      <= cur_d;
            rd_valid_q <= ren;
            last_q     <= ren && is_last;
        end
    end

    assign IF_rd_valid = rd_valid_q;
    assign window_last = last_q;
endmodule

// File: tb/tb_if_scratch_read_module.sv
// tb_if_scratch_read_module: directed checks of window walking, wrap, writer lag,
// short rows, stall and reset behaviour.
module tb_if_scratch_read_module;
    logic       clk = 1'b0;
    logic       rst, start, IF_end_valid, stall;
    logic [3:0] start_IF, end_IF, IF_waddr, filt_len, stride;
    logic [3:0] IF_raddr;
    logic       IF_scratch_ren, IF_rd_valid, window_last, full_done;
    int checks = 0, errors = 0;
    int rv = 0, wl = 0, fd = 0, rn = 0;
    int b_rv, b_wl, b_fd, b_rn;
    logic [3:0] wrap_exp [6] = '{4'd14, 4'd15, 4'd0, 4'd0, 4'd1, 4'd2};

    if_scratch_read_module dut (
        .clk(clk), .rst(rst), .start(start), .start_IF(start_IF), .end_IF(end_IF),
        .IF_end_valid(IF_end_valid), .IF_waddr(IF_waddr), .filt_len(filt_len),
        .stride(stride), .stall(stall), .IF_raddr(IF_raddr),
        .IF_scratch_ren(IF_scratch_ren), .IF_rd_valid(IF_rd_valid),
        .window_last(window_last), .full_done(full_done)
    );

    always #5 clk = ~clk;

    // Per-cycle event counters, sampled mid-cycle when everything is settled
    always @(negedge clk) begin
        rv += int'(IF_rd_valid);
        wl += int'(window_last);
        fd += int'(full_done);
        rn += int'(IF_scratch_ren);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        b_rv = rv; b_wl = wl; b_fd = fd; b_rn = rn;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; IF_end_valid = 1'b0; stall = 1'b0;
        start_IF = 4'd0; end_IF = 4'd0; IF_waddr = 4'd0; filt_len = 4'd1; stride = 4'd1;
        tick; tick;
        chk("rst_ren", 32'(IF_scratch_ren), 0);
        chk("rst_raddr", 32'(IF_raddr), 0);
        chk("rst_rdv", 32'(IF_rd_valid), 0);
        chk("rst_last", 32'(window_last), 0);
        chk("rst_done", 32'(full_done), 0);
        rst = 1'b0;

        // Basic row: 0..7, windows of 3 stepping by 1
        end_IF = 4'd7; IF_end_valid = 1'b1; filt_len = 4'd3; stride = 4'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("t1_init_ren", 32'(IF_scratch_ren), 0);
        clr;
        tick;
        for (int n = 0; n < 18; n++) begin
            chk("t1_ren", 32'(IF_scratch_ren), 1);
            chk("t1_raddr", 32'(IF_raddr), 32'(n / 3 + n % 3));
            tick;
        end
        repeat (4) tick;
        chk("t1_rdv_beats", 32'(rv - b_rv), 18);
        chk("t1_last_beats", 32'(wl - b_wl), 6);
        chk("t1_done_pulses", 32'(fd - b_fd), 1);
        chk("t1_reads", 32'(rn - b_rn), 18);

        // Wrap-around row 14..3, windows of 3 stepping by 2
        start_IF = 4'd14; end_IF = 4'd3; stride = 4'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        clr;
        tick;
        for (int n = 0; n < 6; n++) begin
            chk("t2_ren", 32'(IF_scratch_ren), 1);
            chk("t2_raddr", 32'(IF_raddr), 32'(wrap_exp[n]));
            tick;
        end
        repeat (4) tick;
        chk("t2_rdv_beats", 32'(rv - b_rv), 6);
        chk("t2_last_beats", 32'(wl - b_wl), 2);
        chk("t2_done_pulses", 32'(fd - b_fd), 1);

        // Writer lag: one new slot every 3 cycles, row not yet closed
        start_IF = 4'd0; end_IF = 4'd0; IF_end_valid = 1'b0; IF_waddr = 4'd0;
        filt_len = 4'd2; stride = 4'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        clr;
        tick;
        chk("t3_empty_ren", 32'(IF_scratch_ren), 0);
        for (int k = 1; k <= 5; k++) begin
            tick;
            IF_waddr = 4'(k);
            #1;
            chk("t3_ren_after_write", 32'(IF_scratch_ren), 1);
            chk("t3_raddr", 32'(IF_raddr), 32'(k - 1));
            tick;
            chk("t3_hold1", 32'(IF_scratch_ren), 0);
            tick;
            chk("t3_hold2", 32'(IF_scratch_ren), 0);
        end
        tick; tick;
        chk("t3_rdv_beats", 32'(rv - b_rv), 5);
        chk("t3_last_beats", 32'(wl - b_wl), 2);
        chk("t3_no_done", 32'(fd - b_fd), 0);

        // Short row: 2 slots, window of 4
        start_IF = 4'd5; end_IF = 4'd6; IF_end_valid = 1'b1; IF_waddr = 4'd5;
        filt_len = 4'd4; stride = 4'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        clr;
        chk("t4_init_ren", 32'(IF_scratch_ren), 0);
        tick;
        chk("t4_read_ren", 32'(IF_scratch_ren), 0);
        chk("t4_read_done", 32'(full_done), 0);
        tick;
        chk("t4_done_pulse", 32'(full_done), 1);
        tick;
        chk("t4_done_clear", 32'(full_done), 0);
        chk("t4_reads", 32'(rn - b_rn), 0);

        // Stall for 4 cycles mid-window
        start_IF = 4'd0; end_IF = 4'd15; IF_waddr = 4'd0; filt_len = 4'd4; stride = 4'd4;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("t5_raddr0", 32'(IF_raddr), 0);
        tick;
        chk("t5_raddr1", 32'(IF_raddr), 1);
        tick;
        stall = 1'b1;
        clr;
        #1;
        chk("t5_stall_ren", 32'(IF_scratch_ren), 0);
        chk("t5_trailing_rdv", 32'(IF_rd_valid), 1);
        repeat (3) begin
            tick;
            chk("t5_stall_hold", 32'(IF_scratch_ren), 0);
        end
        tick;
        stall = 1'b0;
        #1;
        chk("t5_stall_rdv_beats", 32'(rv - b_rv), 1);
        chk("t5_stall_reads", 32'(rn - b_rn), 0);
        chk("t5_resume_ren", 32'(IF_scratch_ren), 1);
        chk("t5_resume_raddr", 32'(IF_raddr), 2);
        tick;
        chk("t5_raddr3", 32'(IF_raddr), 3);
        tick;
        chk("t5_raddr4", 32'(IF_raddr), 4);
        chk("t5_window_last", 32'(window_last), 1);
        tick;
        chk("t5_raddr5", 32'(IF_raddr), 5);

        // Reset mid-window, then a fresh row
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("t6_ren", 32'(IF_scratch_ren), 0);
        chk("t6_raddr", 32'(IF_raddr), 0);
        chk("t6_rdv", 32'(IF_rd_valid), 0);
        chk("t6_last", 32'(window_last), 0);
        chk("t6_done", 32'(full_done), 0);
        start_IF = 4'd9; filt_len = 4'd2; stride = 4'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("t6_restart_ren", 32'(IF_scratch_ren), 1);
        chk("t6_restart_raddr", 32'(IF_raddr), 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
